// File: rtl/distribute_pkg.sv
// Helpers shared by the distribute switch family: command splitting and lane slicing.
package distribute_pkg;

  localparam int unsigned MAX_LANES     = 32;
  localparam int unsigned MAX_CMD_WIDTH = 64;

  // Forwarded command width once the destination mask is stripped from the head.
  function automatic int unsigned out_cmd_width(input int unsigned in_cmd_w,
                                                input int unsigned num_out);
    return in_cmd_w - num_out;
  endfunction

  // The mask occupies the top num_out bits. The caller narrows the result to its lane count.
  function automatic logic [MAX_LANES-1:0] extract_mask(input logic [MAX_CMD_WIDTH-1:0] cmd,
                                                        input int unsigned in_cmd_w,
                                                        input int unsigned num_out);
    return MAX_LANES'(cmd >> (in_cmd_w - num_out));
  endfunction

  // Position of the least significant bit of lane k on a flattened multi-lane bus.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/distribute_1xn_one_hot_pipe.sv
// Registered 1-to-N multicast switch. A word is held in one output stage until every lane
// its mask targets has taken it. Lane 0 continues the bus, and the other lanes are local ports.
module distribute_1xn_one_hot_pipe
  import distribute_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_OUT           = 4,
  parameter int IN_COMMAND_WIDTH  = 8,
  parameter int OUT_COMMAND_WIDTH = int'(out_cmd_width(IN_COMMAND_WIDTH, NUM_OUT)),
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_en,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic [DATA_WIDTH-1:0]         i_data_bus,
  input  logic [IN_COMMAND_WIDTH-1:0]   i_cmd,
  output logic [NUM_OUT-1:0]            o_valid,
  input  logic [NUM_OUT-1:0]            o_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] o_data_bus,
  output logic [OUT_COMMAND_WIDTH-1:0]  o_cmd,
  output logic                          o_drop,
  output logic [DROP_CNT_WIDTH-1:0]     o_drop_cnt
);

  logic [NUM_OUT-1:0]           pending;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [OUT_COMMAND_WIDTH-1:0] cmd_q;
  logic [NUM_OUT-1:0]           mask;
  logic                         accept;
  logic                         busy;

  assign mask = NUM_OUT'(extract_mask(MAX_CMD_WIDTH'(i_cmd), IN_COMMAND_WIDTH, NUM_OUT));
  assign busy = |pending;

  // The stage frees up in the same cycle that its last stalled lane accepts (o_ready -> i_ready).
  assign i_ready = i_en & ~|(pending & ~o_ready);
  assign accept  = i_valid & i_ready;

  // NOTE: the data and command holding registers are reset as well, so the idle outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      data_q  <= '0;
      cmd_q   <= '0;
      o_drop  <= 1'b0;
    end else begin
      o_drop <= accept & ~|mask;
      if (accept && (|mask)) begin
        // A new load overrides any lane clears in the same cycle, which keeps back-to-back throughput.
        pending <= mask;
        data_q  <= i_data_bus;
        cmd_q   <= i_cmd[OUT_COMMAND_WIDTH-1:0];
      end else begin
        pending <= pending & ~o_ready;
      end
    end
  end

  assign o_valid = pending;
  assign o_cmd   = busy ? cmd_q : '0;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    assign o_data_bus[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = pending[k] ? data_q : '0;
  end

  sat_counter #(
    .WIDTH (DROP_CNT_WIDTH)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept & ~|mask),
    .count (o_drop_cnt)
  );

endmodule

// File: tb/tb_distribute_1xn_one_hot_pipe.sv
// Scoreboard bench: the driver queues expected words per lane, and a negedge monitor pops and compares them on handshakes.
module tb_distribute_1xn_one_hot_pipe;

  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int ICW = 8;
  localparam int OCW = 4;
  localparam int DCW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_en = 1'b1;
  logic           i_valid = 1'b0;
  logic           i_ready;
  logic [DW-1:0]  i_data_bus = '0;
  logic [ICW-1:0] i_cmd = '0;
  logic [N-1:0]   o_valid;
  logic [N-1:0]   o_ready = '0;
  logic [N*DW-1:0] o_data_bus;
  logic [OCW-1:0] o_cmd;
  logic           o_drop;
  logic [DCW-1:0] o_drop_cnt;

  distribute_1xn_one_hot_pipe #(
    .DATA_WIDTH       (DW),
    .NUM_OUT          (N),
    .IN_COMMAND_WIDTH (ICW),
    .OUT_COMMAND_WIDTH(OCW),
    .DROP_CNT_WIDTH   (DCW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd),
    .o_drop     (o_drop),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [OCW-1:0] cmd;
  } exp_t;

  exp_t        lane_q[N][$];
  bit          exp_drop = 1'b0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Present a word, wait (bounded) for acceptance, and queue its expected deliveries at the accepting edge.
  task automatic send(input logic [DW-1:0] data, input logic [ICW-1:0] cmd,
                      input logic [N-1:0] exp_mask, output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    i_valid    = 1'b1;
    i_data_bus = data;
    i_cmd      = cmd;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (i_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      for (int k = 0; k < N; k++)
        if (exp_mask[k]) lane_q[k].push_back('{data: data, cmd: cmd[OCW-1:0]});
      if (exp_mask == '0) exp_drop = 1'b1;
    end
    #1;
    i_valid = 1'b0;
  endtask

  // Monitor: valid must track the scoreboard. Data and command are compared, and the front entry pops on each handshake.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("valid_lane%0d", k), 64'(o_valid[k]), 64'(lane_q[k].size() != 0));
        if (lane_q[k].size() != 0) begin
          check($sformatf("data_lane%0d", k), 64'(o_data_bus[k*DW +: DW]), 64'(lane_q[k][0].data));
          check($sformatf("cmd_lane%0d", k), 64'(o_cmd), 64'(lane_q[k][0].cmd));
          if (o_ready[k]) void'(lane_q[k].pop_front());
        end else begin
          check($sformatf("dummy_lane%0d", k), 64'(o_data_bus[k*DW +: DW]), 64'd0);
        end
      end
      if (o_valid == '0) check("cmd_idle", 64'(o_cmd), 64'd0);
      check("drop_pulse", 64'(o_drop), 64'(exp_drop));
      exp_drop = 1'b0;
    end
  end

  initial begin
    int w;
    int unsigned c0;

    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset state
    i_cmd = 8'b1111_0000;
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data_bus[63:0]), 64'd0);
    check("rst_cmd", 64'(o_cmd), 64'd0);
    check("rst_ready", 64'(i_ready), 64'd1);
    check("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);

    // Broadcast
    @(posedge clk); #1;
    o_ready = 4'b1111;
    send(32'hDEAD_BEEF, 8'b1111_0101, 4'b1111, w);
    @(negedge clk);
    check("bcast_valid", 64'(o_valid), 64'hF);
    check("bcast_lane3", 64'(o_data_bus[3*DW +: DW]), 64'hDEAD_BEEF);
    check("bcast_cmd", 64'(o_cmd), 64'h5);
    @(posedge clk); #1;
    @(negedge clk);
    check("bcast_clear", 64'(o_valid), 64'd0);

    // Partial drain
    @(posedge clk); #1;
    o_ready = 4'b0010;
    send(32'h1234_5678, 8'b1010_0011, 4'b1010, w);
    @(negedge clk);
    check("drain_valid0", 64'(o_valid), 64'hA);
    check("drain_ready0", 64'(i_ready), 64'd0);
    for (int c = 1; c < 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("drain_valid", 64'(o_valid), 64'h8);
      check("drain_ready", 64'(i_ready), 64'd0);
    end
    @(posedge clk); #1;
    o_ready = 4'b1000;
    send(32'hCAFE_F00D, 8'b0100_0110, 4'b0100, w);
    check("drain_same_cycle_accept", 64'(w), 64'd0);
    o_ready = 4'b1111;
    @(negedge clk);
    check("drain_second_valid", 64'(o_valid), 64'h4);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(32'hA000_0000 + 32'(i), {4'b0001, 4'(i)}, 4'b0001, w);
    check("b2b_cycles", 64'(cyc - c0), 64'd8);
    repeat (2) @(posedge clk);
    #1;

    // Drops and saturation
    send(32'h5555_5555, 8'b0000_1111, 4'b0000, w);
    @(negedge clk);
    check("drop_cnt_one", 64'(o_drop_cnt), 64'd1);
    @(posedge clk); #1;
    for (int i = 1; i < 65535; i++)
      send(32'h5555_5555, 8'b0000_1111, 4'b0000, w);
    @(negedge clk);
    check("drop_cnt_max", 64'(o_drop_cnt), 64'hFFFF);
    @(posedge clk); #1;
    send(32'h5555_5555, 8'b0000_1111, 4'b0000, w);
    @(negedge clk);
    check("drop_cnt_sat", 64'(o_drop_cnt), 64'hFFFF);
    @(posedge clk); #1;

    // Enable low while lanes drain
    o_ready = 4'b0000;
    send(32'h0BAD_CAFE, 8'b0110_1001, 4'b0110, w);
    i_en       = 1'b0;
    i_valid    = 1'b1;
    i_data_bus = 32'hFFFF_0001;
    i_cmd      = 8'b0001_0000;
    @(negedge clk);
    check("en_ready_stalled", 64'(i_ready), 64'd0);
    check("en_valid_held", 64'(o_valid), 64'h6);
    @(posedge clk); #1;
    o_ready = 4'b0110;
    @(negedge clk);
    check("en_ready_free", 64'(i_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("en_drained", 64'(o_valid), 64'd0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_en    = 1'b1;

    // Reset mid-transfer
    o_ready = 4'b0000;
    send(32'h7777_0000, 8'b0110_0011, 4'b0110, w);
    @(negedge clk);
    check("rst_pend_valid", 64'(o_valid), 64'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(o_valid), 64'd0);
    check("rst_mid_data", 64'(o_data_bus[2*DW +: DW]), 64'd0);
    check("rst_mid_cnt", 64'(o_drop_cnt), 64'd0);
    for (int k = 0; k < N; k++) lane_q[k].delete();
    exp_drop = 1'b0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    o_ready = 4'b1111;
    repeat (3) @(posedge clk);
    #1;

    for (int k = 0; k < N; k++)
      check($sformatf("undelivered_lane%0d", k), 64'(lane_q[k].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/distribute_1xn_one_hot_pipe.md
# distribute_1xn_one_hot_pipe

Registered 1-to-N multicast distribute switch for the distribution network. It accepts one word per cycle under a valid/ready handshake. A one-hot-per-lane destination mask in the command head selects which lanes receive the word; the rest of the command is forwarded. The word is held in a single output stage until every targeted lane has accepted it. Lane 0 is the bus continuation to the next switch; lanes 1..NUM_OUT-1 are local node ports.

## Interface
- DATA_WIDTH, 32, payload width.
- NUM_OUT, 4, output lane count, ≥2.
- IN_COMMAND_WIDTH, 8, input command width, ≥NUM_OUT+1.
- OUT_COMMAND_WIDTH, IN_COMMAND_WIDTH-NUM_OUT, derived, forwarded command width.
- DROP_CNT_WIDTH, 16, drop counter width.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  switch enable; low stalls the input.
- i_valid  in  1  input word valid.
- i_ready  out  1  switch can accept this cycle.
- i_data_bus  in  DATA_WIDTH  input word.
- i_cmd  in  IN_COMMAND_WIDTH  mask = i_cmd[IN_COMMAND_WIDTH-1 -: NUM_OUT], bit k targets lane k.
- o_valid  out  NUM_OUT  per-lane valid.
- o_ready  in  NUM_OUT  per-lane downstream ready.
- o_data_bus  out  NUM_OUT*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_cmd  out  OUT_COMMAND_WIDTH  held i_cmd[OUT_COMMAND_WIDTH-1:0], shared by all lanes.
- o_drop  out  1  one-cycle pulse when a zero-mask word is accepted.
- o_drop_cnt  out  DROP_CNT_WIDTH  saturating count of dropped words.

## Operation
- State: pending[NUM_OUT] mask, data_q, cmd_q, drop_cnt.
- The switch is busy when the pending mask is non-zero.
- i_ready = i_en & ~|(pending & ~o_ready). This is the combinational path o_ready → i_ready. The switch is free when every still-pending lane is accepting this cycle.
- Accept condition: i_valid & i_ready.
- Lane k handshake: o_valid[k] & o_ready[k] clears pending[k].
- On accept, with the mask non-zero: pending ← mask, data_q ← i_data_bus, cmd_q ← low command bits. The load takes priority over same-cycle clears, so back-to-back words give full throughput.
- On accept with mask zero: the word is consumed, and no lane goes valid.
  - o_drop pulses next cycle.
  - drop_cnt increments and saturates at all-ones.
- o_valid = pending.
- o_data_bus lane k = data_q when pending[k], else {DATA_WIDTH{1'b0}} (dummy data).
- o_cmd = cmd_q while busy, else zero.
- Lanes drain independently. Once a lane accepts, it deasserts valid even if other lanes are still pending.
- i_en low: i_ready = 0 and no new accept. Pending lanes keep draining, and outputs stay stable apart from per-lane clears.
- i_valid must hold its data and command until accepted. The switch does not check this.

## Timing
- Reset values: pending = 0, o_valid = 0, o_data_bus = 0, o_cmd = 0, o_drop = 0, o_drop_cnt = 0, data_q = 0, cmd_q = 0.
- Reset asserted mid-transfer discards the pending word immediately; no partial delivery is completed after rst_n rises.
- Latency: accept at cycle t → o_valid at t+1.
- Throughput: 1 word/cycle while all targeted lanes are ready.
- Simultaneous events:
  - Clear and load in the same cycle on the same lane: the load wins, and pending[k] = 1 for the new word.
  - A zero-mask accept while the final lane clears: pending becomes 0 and o_drop pulses.
- Counter at max: stays at max, and o_drop still pulses.

## Structure
- Package distribute_pkg: lane-index helper, mask-extraction function, and the OUT_COMMAND_WIDTH derivation shared with the other distribute switches.
- Sub-module sat_counter (width parameter, inc, async active-low reset) for o_drop_cnt; it is reused by future switches.
- Everything else stays flat. No FSM beyond the pending mask: idle when the mask is 0, busy otherwise.

## Test plan
All scenarios use DATA_WIDTH=32, NUM_OUT=4, IN_COMMAND_WIDTH=8.
- Reset check: after reset release, drive i_cmd=8'b1111_0000 with i_valid low → o_valid=0, o_data_bus=0, o_cmd=0, i_ready=1.
- Broadcast: data 32'hDEAD_BEEF, i_cmd=8'b1111_0101, all o_ready=1 → next cycle o_valid=4'b1111, all lanes DEAD_BEEF, o_cmd=4'b0101. Lanes clear after one cycle.
- Partial drain: i_cmd=8'b1010_0011, o_ready=4'b0010 for 3 cycles then 4'b1000.
  - During the 3 cycles: o_valid goes 4'b1010 → 4'b1000, i_ready=0.
  - Lane 3 accepts in the next cycle; a second word is accepted in that same cycle.
- Back-to-back: 8 words, mask 4'b0001, o_ready=1 → 8 consecutive o_valid[0] cycles, order preserved, no bubbles.
- Drop: i_cmd=8'b0000_1111 accepted → no o_valid, o_drop pulses once, o_drop_cnt=1. Repeat 65536 times → o_drop_cnt saturates at 16'hFFFF.
- Enable and reset mid-operation: pend mask 4'b0110 with o_ready=0.
  - Drop i_en → i_ready=0 and the lanes still drain when o_ready rises.
  - Re-pend, then pulse rst_n low → o_valid=0 immediately.
